float8_accum: RTL and testbench



---
 rtl/float8_pkg.sv | 34 +++
 rtl/float8_normalize.sv | 51 +++++
 rtl/float8_accum.sv | 153 +++++++++++++++
 tb/tb_float8_accum.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/float8_pkg.sv
// Shared definitions for the 8-bit float accumulator datapath:
// format widths, special encodings, FSM states and field unpacking.
package float8_pkg;

   localparam int EXP_W = 4;
   localparam int MAN_W = 3;
   localparam int BIAS  = 7;

   localparam logic [7:0] FLOAT_ZERO = 8'h00;
   localparam logic [6:0] SAT_MAG    = 7'h7F;

   typedef enum logic [1:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM
   } accState_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] mant;
   } float8_t;

   // Split a raw 8-bit float into its sign, exponent and mantissa fields.
   function automatic float8_t unpackFloat8(input logic [7:0] value);
      float8_t fields;
      fields.sign = value[7];
      fields.exp  = value[6:3];
      fields.mant = value[2:0];
      return fields;
   endfunction

endpackage

// File: rtl/float8_normalize.sv
// Combinational normalizer: takes a raw magnitude sum (with carry bit) and
// its working exponent, locates the leading one, rebuilds the 8-bit float
// with a truncated mantissa, and saturates or flushes out-of-range exponents.
module float8_normalize
   import float8_pkg::*;
#(
   parameter int GUARD_BITS = 3
) (
   input  logic                      i_sign,
   input  logic signed [5:0]         i_exp,
   input  logic [MAN_W+GUARD_BITS+1:0] i_sum,
   output logic [7:0]                o_result
);

   localparam int SIG_W = 1 + MAN_W + GUARD_BITS;
   localparam int SUM_W = SIG_W + 1;
   localparam int IDX_W = $clog2(SUM_W);

   logic [IDX_W-1:0]  w_msbPos;
   logic [MAN_W-1:0]  w_mant;
   logic signed [5:0] w_exp;

   // Find the leading one, pick the mantissa bits below it and derive the
   // exponent from how far that leading one sits from the normal position.
   always_comb begin
      w_msbPos = '0;
      w_mant   = '0;
      for (int i = 0; i < SUM_W; i++) begin
         if (i_sum[i]) begin
            w_msbPos = IDX_W'(i);
         end
      end
      for (int j = 0; j < MAN_W; j++) begin
         if (int'(w_msbPos) >= (MAN_W - j)) begin
            w_mant[j] = i_sum[w_msbPos - IDX_W'(MAN_W - j)];
         end
      end
      w_exp = i_exp + $signed(6'(w_msbPos)) - 6'(SIG_W - 1);

      if (i_sum == '0) begin
         o_result = FLOAT_ZERO;
      end else if (w_exp > 6'sd15) begin
         o_result = {i_sign, SAT_MAG};
      end else if (w_exp < 6'sd1) begin
         o_result = FLOAT_ZERO;
      end else begin
         o_result = {i_sign, w_exp[3:0], w_mant};
      end
   end

endmodule

// File: rtl/float8_accum.sv
// Running accumulator for 8-bit floats. Each accepted operand walks through
// ALIGN, ADD and NORM before the registered accumulator is rewritten.
module float8_accum
   import float8_pkg::*;
#(
   parameter int GUARD_BITS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_last,
   input  logic       clear,
   output logic [7:0] acc_out,
   output logic       out_valid,
   output logic       busy
);

   localparam int SIG_W = 1 + MAN_W + GUARD_BITS;
   localparam int SUM_W = SIG_W + 1;

   accState_t        r_state;
   logic [7:0]       r_opnd;
   logic             r_last;
   logic [7:0]       r_acc;
   logic             r_outValid;
   logic [SIG_W-1:0] r_sigAcc;
   logic [SIG_W-1:0] r_sigOpnd;
   logic             r_signAcc;
   logic             r_signOpnd;
   logic [EXP_W-1:0] r_exp;
   logic [SUM_W-1:0] r_sum;
   logic             r_sumSign;

   float8_t          w_accF;
   float8_t          w_opF;
   logic [SIG_W-1:0] w_accSig;
   logic [SIG_W-1:0] w_opSig;
   logic [SIG_W-1:0] w_accAligned;
   logic [SIG_W-1:0] w_opAligned;
   logic             w_accSign;
   logic             w_opSign;
   logic [EXP_W-1:0] w_workExp;
   logic [SUM_W-1:0] w_sum;
   logic             w_sumSign;
   logic [7:0]       w_normResult;
   logic             w_handshake;

   assign in_ready    = (r_state == IDLE) & ~clear;
   assign w_handshake = in_valid & in_ready;
   assign busy        = (r_state != IDLE);
   assign acc_out     = r_acc;
   assign out_valid   = r_outValid;

   // Expand both operands to significands and shift the smaller one right;
   // a zero operand contributes nothing and is always treated as positive.
   always_comb begin
      w_accF    = unpackFloat8(r_acc);
      w_opF     = unpackFloat8(r_opnd);
      w_accSig  = (w_accF.exp == '0) ? '0 : {1'b1, w_accF.mant, {GUARD_BITS{1'b0}}};
      w_opSig   = (w_opF.exp == '0) ? '0 : {1'b1, w_opF.mant, {GUARD_BITS{1'b0}}};
      w_accSign = w_accF.sign & (w_accF.exp != '0);
      w_opSign  = w_opF.sign & (w_opF.exp != '0);
      if (w_accF.exp >= w_opF.exp) begin
         w_workExp    = w_accF.exp;
         w_accAligned = w_accSig;
         w_opAligned  = w_opSig >> (w_accF.exp - w_opF.exp);
      end else begin
         w_workExp    = w_opF.exp;
         w_accAligned = w_accSig >> (w_opF.exp - w_accF.exp);
         w_opAligned  = w_opSig;
      end
   end

   // Signed-magnitude add: same signs add, otherwise the smaller magnitude
   // is subtracted from the larger and the larger one's sign is kept.
   always_comb begin
      if (r_signAcc == r_signOpnd) begin
         w_sum     = SUM_W'(r_sigAcc) + SUM_W'(r_sigOpnd);
         w_sumSign = r_signAcc;
      end else if (r_sigAcc >= r_sigOpnd) begin
         w_sum     = SUM_W'(r_sigAcc - r_sigOpnd);
         w_sumSign = r_signAcc;
      end else begin
         w_sum     = SUM_W'(r_sigOpnd - r_sigAcc);
         w_sumSign = r_signOpnd;
      end
   end

   float8_normalize #(
      .GUARD_BITS (GUARD_BITS)
   ) u_normalize (
      .i_sign   (r_sumSign),
      .i_exp    ($signed({2'b00, r_exp})),
      .i_sum    (r_sum),
      .o_result (w_normResult)
   );

   // Operand FSM with its pipeline registers; clear aborts any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_opnd     <= FLOAT_ZERO;
         r_last     <= 1'b0;
         r_acc      <= FLOAT_ZERO;
         r_outValid <= 1'b0;
         r_sigAcc   <= '0;
         r_sigOpnd  <= '0;
         r_signAcc  <= 1'b0;
         r_signOpnd <= 1'b0;
         r_exp      <= '0;
         r_sum      <= '0;
         r_sumSign  <= 1'b0;
      end else begin
         r_outValid <= 1'b0;
         if (clear) begin
            r_state <= IDLE;
            r_acc   <= FLOAT_ZERO;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_handshake) begin
                     r_opnd  <= in_data;
                     r_last  <= in_last;
                     r_state <= ALIGN;
                  end
               end
               ALIGN: begin
                  r_sigAcc   <= w_accAligned;
                  r_sigOpnd  <= w_opAligned;
                  r_signAcc  <= w_accSign;
                  r_signOpnd <= w_opSign;
                  r_exp      <= w_workExp;
                  r_state    <= ADD;
               end
               ADD: begin
                  r_sum     <= w_sum;
                  r_sumSign <= w_sumSign;
                  r_state   <= NORM;
               end
               NORM: begin
                  r_acc      <= w_normResult;
                  r_outValid <= r_last;
                  r_state    <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_float8_accum.sv
// Self-checking bench for float8_accum: directed vector table, multi-cycle
// corner sequences and random operands checked against a value-level model.
module tb_float8_accum;

   localparam int GUARD_BITS = 3;
   localparam int SIG_W      = 4 + GUARD_BITS;
   localparam int NUM_VEC    = 17;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] acc_out;
   logic       out_valid;
   logic       busy;

   int         checkCount = 0;
   int         failCount  = 0;
   logic [7:0] modelAcc   = 8'h00;

   typedef struct {
      logic       doClear;
      logic [7:0] data;
      logic       last;
      logic [7:0] expAcc;
   } vec_t;

   vec_t vecs [NUM_VEC];

   float8_accum #(
      .GUARD_BITS (GUARD_BITS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .clear     (clear),
      .acc_out   (acc_out),
      .out_valid (out_valid),
      .busy      (busy)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Hard stop in case a sequence loses the clock relationship entirely.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Value-level reference: operands as scaled integers, the smaller one
   // truncated to the working exponent's grid, exact signed sum, then
   // renormalised by repeated halving/doubling with truncation.
   function automatic logic [7:0] refAdd(input logic [7:0] a, input logic [7:0] b);
      int ea, eb, ma, mb, ew, va, vb, total, mag;
      logic       neg;
      logic [3:0] expField;
      logic [2:0] manField;
      ea = int'(a[6:3]);
      eb = int'(b[6:3]);
      ma = (ea == 0) ? 0 : (8 + int'(a[2:0])) * (2 ** GUARD_BITS);
      mb = (eb == 0) ? 0 : (8 + int'(b[2:0])) * (2 ** GUARD_BITS);
      if (ea >= eb) begin
         ew = ea;
         mb = mb / (2 ** (ea - eb));
      end else begin
         ew = eb;
         ma = ma / (2 ** (eb - ea));
      end
      va = (a[7] && ea != 0) ? -ma : ma;
      vb = (b[7] && eb != 0) ? -mb : mb;
      total = va + vb;
      if (total == 0) return 8'h00;
      neg = (total < 0);
      mag = neg ? -total : total;
      while (mag >= 2 ** SIG_W) begin
         mag = mag / 2;
         ew  = ew + 1;
      end
      while (mag < 2 ** (SIG_W - 1)) begin
         mag = mag * 2;
         ew  = ew - 1;
      end
      if (ew > 15) return {neg, 7'h7F};
      if (ew < 1) return 8'h00;
      expField = 4'(ew);
      manField = 3'((mag / (2 ** GUARD_BITS)) % 8);
      return {neg, expField, manField};
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Entered and left on a falling edge.
   task automatic doClear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      #1;
      modelAcc = 8'h00;
      checkOutput("clear acc", acc_out, 8'h00);
   endtask

   // Offer one operand, then follow it through the four-cycle operation,
   // checking the handshake timing and the final accumulator value.
   task automatic applyStimulus(input logic [7:0] data, input logic last);
      int         waitCnt;
      logic [7:0] expAcc;
      expAcc   = refAdd(modelAcc, data);
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      #1;
      waitCnt = 0;
      while (!in_ready && waitCnt < 8) begin
         @(negedge clk);
         #1;
         waitCnt++;
      end
      if (!in_ready) begin
         checkOutput("ready timeout", 8'(in_ready), 8'h01);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         if (k > 1) @(negedge clk);
         checkOutput("busy mid-op", 8'(busy), 8'h01);
         checkOutput("ready mid-op", 8'(in_ready), 8'h00);
         checkOutput("out_valid mid-op", 8'(out_valid), 8'h00);
      end
      @(negedge clk);
      checkOutput("busy done", 8'(busy), 8'h00);
      checkOutput("ready done", 8'(in_ready), 8'h01);
      checkOutput("out_valid done", 8'(out_valid), 8'(last));
      checkOutput("acc vs model", acc_out, expAcc);
      modelAcc = expAcc;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'h38, 1'b0, 8'h38};
      vecs[1]  = '{1'b0, 8'h38, 1'b1, 8'h40};
      vecs[2]  = '{1'b1, 8'h3C, 1'b0, 8'h3C};
      vecs[3]  = '{1'b0, 8'h3C, 1'b1, 8'h44};
      vecs[4]  = '{1'b1, 8'h38, 1'b0, 8'h38};
      vecs[5]  = '{1'b0, 8'hB8, 1'b1, 8'h00};
      vecs[6]  = '{1'b0, 8'h38, 1'b0, 8'h38};
      vecs[7]  = '{1'b0, 8'h08, 1'b1, 8'h38};
      vecs[8]  = '{1'b1, 8'h7F, 1'b0, 8'h7F};
      vecs[9]  = '{1'b0, 8'h7F, 1'b1, 8'h7F};
      vecs[10] = '{1'b1, 8'hFF, 1'b0, 8'hFF};
      vecs[11] = '{1'b0, 8'hFF, 1'b1, 8'hFF};
      vecs[12] = '{1'b1, 8'h00, 1'b1, 8'h00};
      vecs[13] = '{1'b1, 8'h40, 1'b0, 8'h40};
      vecs[14] = '{1'b0, 8'hB8, 1'b1, 8'h38};
      vecs[15] = '{1'b1, 8'h08, 1'b0, 8'h08};
      vecs[16] = '{1'b0, 8'h89, 1'b1, 8'h00};

      // Reset state.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      $display("[TB] reset released");
      checkOutput("reset acc", acc_out, 8'h00);
      checkOutput("reset out_valid", 8'(out_valid), 8'h00);
      checkOutput("reset busy", 8'(busy), 8'h00);
      checkOutput("reset ready", 8'(in_ready), 8'h01);

      // Directed vectors.
      for (int v = 0; v < NUM_VEC; v++) begin
         if (vecs[v].doClear) doClear();
         applyStimulus(vecs[v].data, vecs[v].last);
         checkOutput($sformatf("vec%0d acc", v), acc_out, vecs[v].expAcc);
      end

      // Continuous in_valid: a handshake every fourth cycle only.
      doClear();
      in_valid = 1'b1;
      in_data  = 8'h38;
      in_last  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checkOutput($sformatf("stream ready c%0d", i), 8'(in_ready), 8'((i % 4) == 0));
         if ((i % 4) == 0) modelAcc = refAdd(modelAcc, 8'h38);
      end
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("stream acc", acc_out, modelAcc);
      checkOutput("stream acc const", acc_out, 8'h48);

      // Clear while the operation is in ADD: aborted, no out_valid.
      in_valid = 1'b1;
      in_data  = 8'h38;
      in_last  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      #1;
      modelAcc = 8'h00;
      checkOutput("abort acc", acc_out, 8'h00);
      checkOutput("abort busy", 8'(busy), 8'h00);
      checkOutput("abort out_valid", 8'(out_valid), 8'h00);
      @(negedge clk);
      checkOutput("abort out_valid later", 8'(out_valid), 8'h00);
      checkOutput("abort acc later", acc_out, 8'h00);

      // Reset while the operation is in NORM.
      applyStimulus(8'h38, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h38;
      in_last  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      modelAcc = 8'h00;
      checkOutput("rst acc", acc_out, 8'h00);
      checkOutput("rst out_valid", 8'(out_valid), 8'h00);
      checkOutput("rst busy", 8'(busy), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("rst ready", 8'(in_ready), 8'h01);
      checkOutput("rst out_valid later", 8'(out_valid), 8'h00);
      checkOutput("rst acc later", acc_out, 8'h00);
      @(negedge clk);

      // Random operands against the reference model.
      for (int r = 0; r < 60; r++) begin
         if ($urandom_range(0, 7) == 0) doClear();
         applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
